// File: rtl/ddr4_tlul_arbiter_pkg.sv
// +-----------------------------------------------------------------------------+
// | ddr4_tlul_arbiter_pkg                                                       |
// | TL-UL channel A/D bundle types shared by the arbiter and its users.         |
// | Rev 1.0 - initial release                                                   |
// +-----------------------------------------------------------------------------+
`default_nettype none

package ddr4_tlul_arbiter_pkg;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

`default_nettype wire

// File: rtl/ddr4_tlul_arbiter.sv
// +-----------------------------------------------------------------------------+
// | ddr4_tlul_arbiter                                                           |
// | Round-robin sharing of one DDR4 TL-UL port among NUM_HOSTS hosts, with      |
// | in-order D routing via a host-index FIFO. Optional macro DDR4_ARB_PERF_EN   |
// | adds per-host saturating accepted-request counters on perf_cnt_o.           |
// | Rev 1.0 - initial release                                                   |
// +-----------------------------------------------------------------------------+
`default_nettype none

module ddr4_tlul_arbiter
    import ddr4_tlul_arbiter_pkg::*;
#(
    parameter int NUM_HOSTS       = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        calib_done_i,
    input  tl_h2d_t     tl_h_i [NUM_HOSTS],
    output tl_d2h_t     tl_h_o [NUM_HOSTS],
    output tl_h2d_t     tl_ddr_o,
    input  tl_d2h_t     tl_ddr_i,
`ifdef DDR4_ARB_PERF_EN
    output logic [31:0] perf_cnt_o [NUM_HOSTS],
`endif
    output logic        err_unexp_o
);

    localparam int IDX_W = $clog2(NUM_HOSTS);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_HOSTS - 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);

    logic [IDX_W-1:0] rr_q;
    logic [IDX_W-1:0] rr_d;
    logic             lock_q;
    logic             lock_d;
    logic [IDX_W-1:0] lock_idx_q;
    logic [IDX_W-1:0] lock_idx_d;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             err_q;
    logic             err_d;
    logic [IDX_W-1:0] fifo_q [MAX_OUTSTANDING];

    logic [IDX_W-1:0] scan_idx;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_found;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_vld;
    logic             a_hs;
    logic             d_hs;
    logic             fifo_empty;
    logic             fifo_full;
    logic [IDX_W-1:0] head_idx;

    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == MAX_CNT);
    assign head_idx   = fifo_q[rd_ptr_q];

    // Search upward from the round-robin pointer, wrapping at the last host.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = rr_q;
        scan_idx  = rr_q;
        for (int k = 0; k < NUM_HOSTS; k++) begin
            if (!sel_found && tl_h_i[scan_idx].a_valid) begin
                sel_found = 1'b1;
                sel_idx   = scan_idx;
            end
            scan_idx = (scan_idx == LAST_IDX) ? '0 : scan_idx + IDX_W'(1);
        end
    end

    // A locked host never needs the occupancy check: it was granted below MAX.
    always_comb begin
        gnt_idx = lock_q ? lock_idx_q : sel_idx;
        gnt_vld = rst_ni && calib_done_i && (lock_q || (!fifo_full && sel_found));
        a_hs    = gnt_vld && tl_h_i[gnt_idx].a_valid && tl_ddr_i.a_ready;
        d_hs    = !fifo_empty && tl_ddr_i.d_valid && tl_h_i[head_idx].d_ready;
    end

    // With no outstanding entry a stray D beat is swallowed rather than stalled.
    always_comb begin
        tl_ddr_o         = tl_h_i[gnt_idx];
        tl_ddr_o.a_valid = gnt_vld && tl_h_i[gnt_idx].a_valid;
        tl_ddr_o.d_ready = rst_ni && (fifo_empty ? tl_ddr_i.d_valid
                                                 : tl_h_i[head_idx].d_ready);
    end

    always_comb begin
        for (int i = 0; i < NUM_HOSTS; i++) begin
            tl_h_o[i] = '0;
            if (rst_ni && !fifo_empty && (head_idx == IDX_W'(i))) begin
                tl_h_o[i] = tl_ddr_i;
            end
            tl_h_o[i].a_ready = gnt_vld && (gnt_idx == IDX_W'(i)) && tl_ddr_i.a_ready;
        end
    end

    always_comb begin
        rr_d       = rr_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        if (a_hs) begin
            lock_d   = 1'b0;
            rr_d     = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + IDX_W'(1);
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
        end else if (tl_ddr_o.a_valid) begin
            lock_d     = 1'b1;
            lock_idx_d = gnt_idx;
        end
        if (d_hs) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        case ({a_hs, d_hs})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
        if (tl_ddr_i.d_valid && fifo_empty) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            rr_q       <= rr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
        end
    end

    // Entry storage needs no reset: occupancy is tracked solely by cnt_q.
    always_ff @(posedge clk_i) begin
        if (a_hs) begin
            fifo_q[wr_ptr_q] <= gnt_idx;
        end
    end

    assign err_unexp_o = err_q;

`ifdef DDR4_ARB_PERF_EN
    logic [31:0] perf_q [NUM_HOSTS];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_HOSTS; i++) begin
                perf_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_HOSTS; i++) begin
                if (a_hs && (gnt_idx == IDX_W'(i)) && (perf_q[i] != 32'hFFFF_FFFF)) begin
                    perf_q[i] <= perf_q[i] + 32'd1;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_HOSTS; i++) begin
            perf_cnt_o[i] = perf_q[i];
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_ddr4_tlul_arbiter.sv
// +-----------------------------------------------------------------------------+
// | tb_ddr4_tlul_arbiter                                                        |
// | Random-traffic scoreboard bench for ddr4_tlul_arbiter.                      |
// | Rev 1.0 - initial release                                                   |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_ddr4_tlul_arbiter;
    import ddr4_tlul_arbiter_pkg::*;

    localparam int N    = 4;
    localparam int MAXO = 4;

    logic    clk = 1'b0;
    logic    rst_n;
    logic    calib;
    tl_h2d_t h_req [N];
    tl_d2h_t h_rsp [N];
    tl_h2d_t ddr_req;
    tl_d2h_t ddr_rsp;
    logic    err;
`ifdef DDR4_ARB_PERF_EN
    logic [31:0] perf [N];
`endif

    always #5 clk = ~clk;

    ddr4_tlul_arbiter #(.NUM_HOSTS(N), .MAX_OUTSTANDING(MAXO)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .calib_done_i (calib),
        .tl_h_i       (h_req),
        .tl_h_o       (h_rsp),
        .tl_ddr_o     (ddr_req),
        .tl_ddr_i     (ddr_rsp),
`ifdef DDR4_ARB_PERF_EN
        .perf_cnt_o   (perf),
`endif
        .err_unexp_o  (err)
    );

    typedef struct {
        int          host;
        logic [31:0] data;
        logic [7:0]  src;
    } exp_t;

    exp_t    exp_q [$];
    tl_h2d_t pend_q [$];

    int          n_chk  = 0;
    int          n_fail = 0;
    int          rr_m, lock_h, seq;
    bit          lock_m, err_m, chk_en;
    int unsigned perf_m [N];
    bit          rand_en, resp_en;
    int          ar_mode;
    bit          acc_a [N];
    bit          acc_d_ddr;

    function automatic logic [31:0] resp_of(tl_h2d_t r);
        return r.a_data ^ r.a_address ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic new_req(input int i);
        h_req[i]           = '0;
        h_req[i].a_valid   = 1'b1;
        h_req[i].a_opcode  = 3'($urandom_range(0, 1) * 4);
        h_req[i].a_size    = 2'd2;
        h_req[i].a_mask    = 4'hF;
        h_req[i].a_address = $urandom;
        h_req[i].a_data    = $urandom;
        h_req[i].a_source  = 8'((i << 6) | (seq & 63));
        seq++;
    endtask

    task automatic drive();
        tl_h2d_t r;
        for (int i = 0; i < N; i++) begin
            if (acc_a[i]) h_req[i].a_valid = 1'b0;
            if (!h_req[i].a_valid && rand_en && ($urandom % 3 == 0)) new_req(i);
            h_req[i].d_ready = ($urandom % 4) != 0;
        end
        case (ar_mode)
            0:       ddr_rsp.a_ready = ($urandom % 3) != 0;
            1:       ddr_rsp.a_ready = 1'b1;
            default: ddr_rsp.a_ready = 1'b0;
        endcase
        if (acc_d_ddr) ddr_rsp.d_valid = 1'b0;
        if (!ddr_rsp.d_valid && resp_en && pend_q.size() > 0 && ($urandom % 2 == 0)) begin
            r = pend_q.pop_front();
            ddr_rsp.d_valid  = 1'b1;
            ddr_rsp.d_opcode = (r.a_opcode == 3'd4) ? 3'd1 : 3'd0;
            ddr_rsp.d_data   = resp_of(r);
            ddr_rsp.d_source = r.a_source;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive();
    endtask

    // Monitor: D routing against the scoreboard, then A grant against the round-robin rules.
    always @(negedge clk) begin
        int  g, hd, cnt_before;
        bit  gv;
        for (int i = 0; i < N; i++) acc_a[i] = h_req[i].a_valid && h_rsp[i].a_ready;
        acc_d_ddr  = ddr_rsp.d_valid && ddr_req.d_ready;
        cnt_before = exp_q.size();
        if (chk_en) begin
            chk("err_unexp", err, err_m);
            if (exp_q.size() == 0) begin
                chk("d_ready_empty", ddr_req.d_ready, ddr_rsp.d_valid);
                for (int i = 0; i < N; i++) chk("d_valid_nohead", h_rsp[i].d_valid, 0);
                if (ddr_rsp.d_valid) err_m = 1'b1;
            end else begin
                hd = exp_q[0].host;
                chk("d_ready_head", ddr_req.d_ready, h_req[hd].d_ready);
                for (int i = 0; i < N; i++)
                    chk("d_valid_route", h_rsp[i].d_valid, (i == hd) ? ddr_rsp.d_valid : 1'b0);
                if (ddr_rsp.d_valid && h_req[hd].d_ready) begin
                    chk("d_data", h_rsp[hd].d_data, exp_q[0].data);
                    chk("d_source", h_rsp[hd].d_source, exp_q[0].src);
                    void'(exp_q.pop_front());
                end
            end

            gv = 1'b0;
            g  = 0;
            if (calib) begin
                if (lock_m) begin
                    gv = 1'b1;
                    g  = lock_h;
                end else if (cnt_before < MAXO) begin
                    for (int k = 0; k < N; k++) begin
                        if (!gv && h_req[(rr_m + k) % N].a_valid) begin
                            gv = 1'b1;
                            g  = (rr_m + k) % N;
                        end
                    end
                end
            end
            chk("ddr_a_valid", ddr_req.a_valid, gv);
            for (int i = 0; i < N; i++)
                chk("host_a_ready", h_rsp[i].a_ready, (gv && i == g) ? ddr_rsp.a_ready : 1'b0);
            if (gv) begin
                chk("a_address", ddr_req.a_address, h_req[g].a_address);
                chk("a_data", ddr_req.a_data, h_req[g].a_data);
                chk("a_source", ddr_req.a_source, h_req[g].a_source);
                if (ddr_rsp.a_ready) begin
                    exp_q.push_back('{host: g, data: resp_of(h_req[g]), src: h_req[g].a_source});
                    rr_m   = (g + 1) % N;
                    lock_m = 1'b0;
                    perf_m[g]++;
                end else begin
                    lock_m = 1'b1;
                    lock_h = g;
                end
            end
        end
        if (ddr_req.a_valid && ddr_rsp.a_ready) pend_q.push_back(ddr_req);
    end

    initial begin
        int  t;
        bit  idle;
        rst_n   = 1'b0;
        calib   = 1'b0;
        rand_en = 1'b0;
        resp_en = 1'b1;
        ar_mode = 0;
        chk_en  = 1'b0;
        seq     = 0;
        ddr_rsp = '0;
        ddr_rsp.d_valid = 1'b1;
        for (int i = 0; i < N; i++) begin
            new_req(i);
            perf_m[i] = 0;
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ddr_a_valid", ddr_req.a_valid, 0);
        chk("rst_ddr_d_ready", ddr_req.d_ready, 0);
        chk("rst_err", err, 0);
        for (int i = 0; i < N; i++) begin
            chk("rst_a_ready", h_rsp[i].a_ready, 0);
            chk("rst_d_valid", h_rsp[i].d_valid, 0);
        end

        @(posedge clk);
        #1;
        ddr_rsp.d_valid = 1'b0;
        rst_n  = 1'b1;
        rr_m   = 0;
        lock_m = 1'b0;
        lock_h = 0;
        err_m  = 1'b0;
        chk_en = 1'b1;

        // All hosts requesting while calibration is pending.
        repeat (20) step();
        step();
        calib = 1'b1;
        @(negedge clk);
        chk("calib_first_valid", ddr_req.a_valid, 1);
        chk("calib_first_host0", ddr_req.a_source, h_req[0].a_source);

        rand_en = 1'b1;
        repeat (2000) step();

        // Withhold responses so the outstanding limit is reached.
        resp_en = 1'b0;
        ar_mode = 1;
        repeat (40) step();
        resp_en = 1'b1;

        // Stall A repeatedly to exercise the lock.
        repeat (60) begin
            ar_mode = 2;
            repeat (5) step();
            ar_mode = 1;
            step();
        end
        ar_mode = 0;
        repeat (500) step();

        rand_en = 1'b0;
        ar_mode = 1;
        t       = 0;
        idle    = 1'b0;
        while (t < 2000 && !idle) begin
            step();
            t++;
            idle = (pend_q.size() == 0) && (exp_q.size() == 0) && !ddr_rsp.d_valid;
            for (int i = 0; i < N; i++) if (h_req[i].a_valid) idle = 1'b0;
        end
        chk("drain_done", idle, 1);

        // Unexpected D beat with nothing outstanding.
        step();
        ddr_rsp.d_valid  = 1'b1;
        ddr_rsp.d_data   = 32'hDEAD_BEEF;
        ddr_rsp.d_source = 8'h3F;
        @(negedge clk);
        chk("unexp_d_ready", ddr_req.d_ready, 1);
        repeat (5) step();
        @(negedge clk);
        chk("err_sticky", err, 1);

`ifdef DDR4_ARB_PERF_EN
        for (int i = 0; i < N; i++) chk("perf_cnt", perf[i], perf_m[i]);
`endif

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
